// File: rtl/clock_switcher.sv
// clock_switcher: slave heartbeat monitor plus glitch-free clock-mux handoff sequencer on the master clock.
// Optional CLOCK_SWITCHER_AUTO_FALLBACK_EN: automatic return to master when the active slave goes bad.
module clock_switcher #(
   parameter int SYNC_STAGES = 2,
   parameter int BAD_TIMEOUT = 64,
   parameter int GOOD_EDGES  = 16,
   parameter int GATE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic slaveHeartbeat,
   input  logic clockSwitch,
   output logic activeClock,
   output logic slaveClockBad,
   output logic clockSelect,
   output logic clockEnable,
   output logic switching
);
   localparam int GW = $clog2(BAD_TIMEOUT + 1);
   localparam int NW = $clog2(GOOD_EDGES + 1);
   localparam int CW = $clog2(GATE_CYCLES + 1);
   localparam logic [GW-1:0] GAP_MAX   = GW'(BAD_TIMEOUT);
   localparam logic [GW-1:0] GAP_LAST  = GW'(BAD_TIMEOUT - 1);
   localparam logic [NW-1:0] GOOD_LAST = NW'(GOOD_EDGES - 1);
   localparam logic [CW-1:0] GATE_LOAD = CW'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GATE_OFF, GATE_ON} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic hb_prev, hb_edge, timeout;
   logic [GW-1:0] gap_cnt;
   logic [NW-1:0] good_cnt;
   state_t state, state_d;
   logic [CW-1:0] gate_cnt, gate_cnt_d;
   logic target, target_d, sel_d, en_d, act_d, start, abort;

   assign hb_edge = sync_q[SYNC_STAGES-1] ^ hb_prev;
   // an edge in the timeout cycle suppresses the bad declaration
   assign timeout = !hb_edge && gap_cnt == GAP_LAST;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync_q        <= '0;
         hb_prev       <= 1'b0;
         gap_cnt       <= '0;
         good_cnt      <= '0;
         slaveClockBad <= 1'b1;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], slaveHeartbeat};
         hb_prev <= sync_q[SYNC_STAGES-1];
         gap_cnt <= hb_edge ? '0 : (gap_cnt == GAP_MAX ? gap_cnt : gap_cnt + 1'b1);
         if (timeout) begin
            slaveClockBad <= 1'b1;
            good_cnt      <= '0;
         end else if (hb_edge && slaveClockBad) begin
            good_cnt <= good_cnt + 1'b1;
            if (good_cnt == GOOD_LAST) slaveClockBad <= 1'b0;
         end
      end

   always_comb begin
      state_d    = state;
      gate_cnt_d = gate_cnt;
      target_d   = target;
      sel_d      = clockSelect;
      en_d       = clockEnable;
      act_d      = activeClock;
`ifdef CLOCK_SWITCHER_AUTO_FALLBACK_EN
      start = (clockSwitch && (activeClock || !slaveClockBad)) || (activeClock && slaveClockBad);
`else
      start = clockSwitch && (activeClock || !slaveClockBad);
`endif
      abort = target && slaveClockBad;
      case (state)
         IDLE:
            if (start) begin
               state_d    = GATE_OFF;
               gate_cnt_d = GATE_LOAD;
               target_d   = !activeClock;
               en_d       = 1'b0;
            end
         GATE_OFF:
            if (abort || gate_cnt == '0) begin
               state_d    = GATE_ON;
               gate_cnt_d = GATE_LOAD;
               sel_d      = abort ? clockSelect : target;
            end else gate_cnt_d = gate_cnt - 1'b1;
         GATE_ON:
            if (gate_cnt == '0) begin
               state_d = IDLE;
               en_d    = 1'b1;
               act_d   = clockSelect;
            end else gate_cnt_d = gate_cnt - 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         gate_cnt    <= '0;
         target      <= 1'b0;
         clockSelect <= 1'b0;
         clockEnable <= 1'b1;
         activeClock <= 1'b0;
         switching   <= 1'b0;
      end else begin
         state       <= state_d;
         gate_cnt    <= gate_cnt_d;
         target      <= target_d;
         clockSelect <= sel_d;
         clockEnable <= en_d;
         activeClock <= act_d;
         switching   <= state_d != IDLE;
      end
endmodule

// File: doc/clock_switcher.md
# clock_switcher

Sequencing partner of the clock-switch controller in the FPGA clock path. Monitors a slave-clock heartbeat to produce `slaveClockBad`, executes the glitch-free handoff requested on `clockSwitch`, and reports the resulting `activeClock`, closing the loop with the controller. Runs entirely on the always-present master clock and drives the select and enable of the downstream clock mux.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `slaveHeartbeat`, minimum 2.
- `BAD_TIMEOUT`, 64: cycles without a heartbeat edge before the slave is declared bad.
- `GOOD_EDGES`, 16: consecutive in-time heartbeat edges required to clear bad.
- `GATE_CYCLES`, 4: cycles `clockEnable` is held low on each side of a select change, minimum 1.
- `clk` in 1: master clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `slaveHeartbeat` in 1: asynchronous toggle derived from the slave clock (divided slave clock).
- `clockSwitch` in 1: level request from the controller; acted on only in IDLE.
- `activeClock` out 1: committed clock, 0 = master, 1 = slave.
- `slaveClockBad` out 1: slave heartbeat missing or not yet qualified.
- `clockSelect` out 1: registered mux select, 0 = master.
- `clockEnable` out 1: registered downstream clock gate, 1 = pass.
- `switching` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Heartbeat monitor.**
  - `slaveHeartbeat` passes through `SYNC_STAGES` flops. Either edge of the synchronized signal counts as a heartbeat edge.
  - `gapCnt` clears on every edge and otherwise increments, saturating at `BAD_TIMEOUT`.
  - When `gapCnt` reaches `BAD_TIMEOUT`: `slaveClockBad` is set to 1 and `goodCnt` is cleared to 0.
  - While bad, each edge increments `goodCnt`. A timeout clears `goodCnt` again.
  - When `goodCnt` reaches `GOOD_EDGES`: `slaveClockBad` is set to 0.
  - An edge in the same cycle that `gapCnt` would reach the timeout wins: no bad declaration.
- **Switch FSM.** States are IDLE, GATE_OFF and GATE_ON.
  - **IDLE → GATE_OFF.** Taken when `clockSwitch`=1 and the target is allowed. Target is `!activeClock`. Master is always allowed; slave is allowed only if `slaveClockBad`=0. On this transition: `clockEnable`←0, load `gateCnt`.
  - **GATE_OFF → GATE_ON.** Taken after `GATE_CYCLES` cycles. On this transition: `clockSelect`←target.
  - **Abort.** If the target is slave and `slaveClockBad` rises while in GATE_OFF, go to GATE_ON with `clockSelect` unchanged.
  - **GATE_ON → IDLE.** Taken after `GATE_CYCLES` cycles. On this transition: `clockEnable`←1, `activeClock`←`clockSelect`.
- `clockSelect` never changes while `clockEnable`=1.
- `clockSwitch` is ignored outside IDLE. A request still held after completion is re-evaluated against the new `activeClock`.
- **Reset values:**
  - Outputs: `activeClock`=0, `clockSelect`=0, `clockEnable`=1, `slaveClockBad`=1, `switching`=0.
  - Internal: FSM in IDLE, all counters 0, synchronizer flops 0.
- Asserting `rst_n` mid-switch returns the block to reset values immediately, i.e. master selected and enabled.

## Timing
- All outputs are registered.
- With a request sampled in IDLE at cycle N:
  - `clockEnable`=0 from N+1.
  - `clockSelect` changes at N+1+G.
  - `clockEnable`=1 and `activeClock` changes at N+1+2G, where G = `GATE_CYCLES`.
- Total request-to-commit latency is 2G+1 cycles: 9 cycles at default.
- `switching` is high from N+1 through N+2G.
- Bad detection: `slaveClockBad` rises `BAD_TIMEOUT` cycles after the last synchronized edge, which is `SYNC_STAGES` cycles after the last real toggle.
- Recovery: `slaveClockBad` falls on the cycle after the `GOOD_EDGES`th qualifying edge.

## Configuration
- Macro: `CLOCK_SWITCHER_AUTO_FALLBACK_EN`.
- **Defined:** in IDLE with `activeClock`=1 and `slaveClockBad`=1, the FSM starts a switch to master without any `clockSwitch` request, using the identical sequence and timing. If `clockSwitch` is asserted in the same cycle, exactly one switch occurs.
- **Undefined:** the block stays on the slave until `clockSwitch` is asserted. Since the controller only requests switches while the slave is good, the clock remains on a dead slave until the heartbeat recovers.

## Test plan
- **Reset and qualification.** Release reset, toggle heartbeat every 4 cycles → `slaveClockBad`=1 until the 16th synchronized edge, then 0; `activeClock`=0, `clockEnable`=1 throughout.
- **Switch to slave.** Slave good, pulse `clockSwitch`=1 at cycle N → `clockEnable` low N+1..N+8, `clockSelect`=1 at N+5, `activeClock`=1 and `clockEnable`=1 at N+9.
- **Abort.** Stop heartbeat so the timeout fires during GATE_OFF of a switch to slave → `clockSelect` stays 0, `clockEnable` returns to 1 four cycles later, `activeClock` stays 0.
- **Timeout.** On slave, stop heartbeat → `slaveClockBad`=1 exactly 64 cycles after the last synchronized edge. Then:
  - with `CLOCK_SWITCHER_AUTO_FALLBACK_EN`: `activeClock`=0 nine cycles later;
  - without it: `activeClock` remains 1.
- **Reset mid-switch.** Pulse `rst_n` low during GATE_ON → outputs immediately at reset values: `clockSelect`=0, `clockEnable`=1, `slaveClockBad`=1.
- **Request filtering.** Hold `clockSwitch`=1 throughout a switch → no second switch starts until the request is re-evaluated in IDLE; a request with `slaveClockBad`=1 on master is ignored.
